video_timing_regen: RTL

//  Parametrised successor of the fixed 24-bit pixel output stage of the MIPI-to-parallel path.

---
 rtl/video_timing_regen.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/video_timing_regen.sv
// video_timing_regen: byte2pix fv/lv video in, fixed H_ACTIVE x V_ACTIVE parallel video out
// with regenerated hs/vs pulses, pad/truncate of bad lines and a frame-locked colour swizzle.

module video_timing_swz #(
  parameter int COMP_W = 8
) (
  input  logic [1:0]          ord,
  input  logic [3*COMP_W-1:0] px,
  output logic [3*COMP_W-1:0] swz
);
  logic [COMP_W-1:0] r, g, b;
  assign {r, g, b} = px;

  always_comb begin
    case (ord)
      2'd1:    swz = {r, b, g};
      2'd2:    swz = {b, g, r};
      2'd3:    swz = {g, r, b};
      default: swz = {r, g, b};
    endcase
  end
endmodule

module video_timing_regen #(
  parameter int PPC      = 1,
  parameter int COMP_W   = 8,
  parameter int H_ACTIVE = 1920,
  parameter int V_ACTIVE = 1080,
  parameter int HS_WIDTH = 44,
  parameter int VS_WIDTH = 5,
  parameter int PAD_VAL  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fv_i,
  input  logic                     lv_i,
  input  logic [PPC*3*COMP_W-1:0]  pd_i,
  input  logic [1:0]               ord_i,
  input  logic                     clr_i,
  output logic [PPC*3*COMP_W-1:0]  pix_o,
  output logic                     de_o,
  output logic                     hs_o,
  output logic                     vs_o,
  output logic [2:0]               err_o
);
  localparam int PW    = 3*COMP_W;
  localparam int BEATS = H_ACTIVE/PPC;
  localparam int BW    = $clog2(BEATS+1);
  localparam int LW    = $clog2(V_ACTIVE+2);
  localparam int HW    = $clog2(HS_WIDTH+1);
  localparam int VW    = $clog2(VS_WIDTH+1);
  localparam logic [BW-1:0]     BEATS_C = BW'(BEATS);
  localparam logic [LW-1:0]     LMAX    = LW'(V_ACTIVE+1);
  localparam logic [LW-1:0]     LEXP    = LW'(V_ACTIVE);
  localparam logic [PW-1:0]     PAD_PIX = {3{COMP_W'(PAD_VAL)}};
  localparam logic [PPC*PW-1:0] PAD_BEAT = {PPC{PAD_PIX}};

  typedef enum logic [1:0] {IDLE, ACTIVE, PAD, DROP} state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [LW-1:0]     lcnt_q, lcnt_d;
  logic [HW-1:0]     hcnt_q, hcnt_d;
  logic [VW-1:0]     vcnt_q, vcnt_d;
  logic              fv_q, lv_q, in_frame_q, in_frame_d;
  logic [1:0]        ord_q, ord_eff;
  logic              fv_rise, fv_fall, lv_rise, start, line_go, pad;
  logic              de_d;
  logic [PPC*PW-1:0] pix_d;
  logic [2:0]        err_set, err_d;
  logic [PPC-1:0][PW-1:0] pd_lane, swz_lane;

  // fv_q resets high so a frame already running at reset release is not taken as a new one
  assign fv_rise = fv_i & ~fv_q;
  assign fv_fall = ~fv_i & fv_q & in_frame_q;
  assign lv_rise = lv_i & ~lv_q;
  assign start   = lv_rise & fv_i & (in_frame_q | fv_rise);
  assign ord_eff = fv_rise ? ord_i : ord_q;
  assign in_frame_d = fv_i & (in_frame_q | fv_rise);

  assign pd_lane = pd_i;
  for (genvar l = 0; l < PPC; l++) begin : g_lane
    video_timing_swz #(.COMP_W(COMP_W)) u_swz (
      .ord (ord_eff),
      .px  (pd_lane[l]),
      .swz (swz_lane[l])
    );
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    de_d    = 1'b0;
    pix_d   = '0;
    line_go = 1'b0;
    pad     = 1'b0;
    err_set = '0;
    case (state_q)
      IDLE: line_go = start;
      ACTIVE:
        if (lv_i) begin
          if (bcnt_q == BEATS_C) begin
            state_d    = DROP;
            err_set[1] = 1'b1;
          end else begin
            de_d   = 1'b1;
            pix_d  = swz_lane;
            bcnt_d = bcnt_q + 1'b1;
          end
        end else if (bcnt_q == BEATS_C) begin
          state_d = IDLE;
        end else begin
          err_set[0] = 1'b1;
          pad        = 1'b1;
        end
      PAD: begin
        line_go = start;
        pad     = ~start;
      end
      DROP: if (!lv_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // first pad beat goes out on the clock lv_i drops, so data and pad stay contiguous
    if (pad) begin
      de_d    = 1'b1;
      pix_d   = PAD_BEAT;
      bcnt_d  = bcnt_q + 1'b1;
      state_d = ((bcnt_q + 1'b1) == BEATS_C) ? IDLE : PAD;
    end
    if (line_go) begin
      de_d    = 1'b1;
      pix_d   = swz_lane;
      bcnt_d  = BW'(1);
      state_d = ACTIVE;
    end

    lcnt_d = fv_rise ? '0 : lcnt_q;
    if (line_go && lcnt_d != LMAX) lcnt_d = lcnt_d + 1'b1;
    err_set[2] = fv_fall && (lcnt_q != LEXP);

    hcnt_d = line_go ? HW'(HS_WIDTH) : (hcnt_q != '0 ? hcnt_q - 1'b1 : '0);
    vcnt_d = fv_rise ? VW'(VS_WIDTH) : (vcnt_q != '0 ? vcnt_q - 1'b1 : '0);
    err_d  = (clr_i ? 3'b000 : err_o) | err_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bcnt_q     <= '0;
      lcnt_q     <= '0;
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      fv_q       <= 1'b1;
      lv_q       <= 1'b1;
      in_frame_q <= 1'b0;
      ord_q      <= 2'd0;
      pix_o      <= '0;
      de_o       <= 1'b0;
      hs_o       <= 1'b0;
      vs_o       <= 1'b0;
      err_o      <= '0;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      lcnt_q     <= lcnt_d;
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      fv_q       <= fv_i;
      lv_q       <= lv_i;
      in_frame_q <= in_frame_d;
      if (fv_rise) ord_q <= ord_i;
      pix_o      <= pix_d;
      de_o       <= de_d;
      hs_o       <= (hcnt_d != '0);
      vs_o       <= (vcnt_d != '0);
      err_o      <= err_d;
    end
  end
endmodule
